// File: rtl/rr_arb8x16_if.sv
// rr_arb8x16_if: request, data and grant bundle for the 8-way round-robin arbiter
interface rr_arb8x16_if #(parameter int WIDTH = 16);
  logic [7:0] req;
  logic [7:0] done;
  logic [WIDTH-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
  logic [7:0] gnt;
  logic [2:0] owner;
  logic busy;
  logic [WIDTH-1:0] out;
  logic timeout;
  modport master (
    output req, done, i0, i1, i2, i3, i4, i5, i6, i7,
    input  gnt, owner, busy, out, timeout
  );
  modport slave (
    input  req, done, i0, i1, i2, i3, i4, i5, i6, i7,
    output gnt, owner, busy, out, timeout
  );
endinterface

// File: rtl/rr_arb8x16.sv
// rr_arb8x16: round-robin arbiter sharing one OR-merged WIDTH-bit bus between 8 requesters.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive grant cycles.
module rr_arb8x16 #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 16
) (
  input logic       clk,
  input logic       rst_n,
  rr_arb8x16_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [7:0] gnt;
  logic [2:0] owner, ptr, sel;
  logic busy, hit, rel, force_rel;
  logic [WIDTH-1:0] out, merged;
  logic [WIDTH-1:0] d [8];
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be within 2..255");
  end
  always_comb begin
    d[0] = bus.i0;
    d[1] = bus.i1;
    d[2] = bus.i2;
    d[3] = bus.i3;
    d[4] = bus.i4;
    d[5] = bus.i5;
    d[6] = bus.i6;
    d[7] = bus.i7;
  end
  // the last owner sits at lowest priority: scan starts just above it
  assign ptr = owner + 3'd1;
  always_comb begin
    sel = ptr;
    hit = 1'b0;
    for (int k = 0; k < 8; k++)
      if (!hit && bus.req[ptr + 3'(k)]) begin
        sel = ptr + 3'(k);
        hit = 1'b1;
      end
  end
  always_comb begin
    merged = '0;
    for (int k = 0; k < 8; k++) merged |= {WIDTH{gnt[k]}} & d[k];
  end
  assign rel = !bus.req[owner] || bus.done[owner];
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold;
  logic timeout;
  assign force_rel = !rel && hold == 8'(MAX_HOLD - 1);
  assign bus.timeout = timeout;
`else
  assign force_rel = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= 3'd7;
      busy  <= 1'b0;
      out   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold    <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      out <= merged;
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      if (state == IDLE) begin
        if (hit) begin
          state <= GRANT;
          gnt   <= 8'd1 << sel;
          owner <= sel;
          busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold <= '0;
`endif
        end
      end else if (rel || force_rel) begin
        state <= IDLE;
        gnt   <= '0;
        busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout <= force_rel;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
        hold <= hold + 8'd1;
`endif
      end
    end
  assign bus.gnt   = gnt;
  assign bus.owner = owner;
  assign bus.busy  = busy;
  assign bus.out   = out;
  a_onehot_gnt: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
endmodule

// File: tb/tb_rr_arb8x16.sv
// tb_rr_arb8x16: randomized + directed scoreboard bench for rr_arb8x16 against a cycle-level reference model.
module tb_rr_arb8x16;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
  localparam bit TO = 1'b1;
`else
  localparam int MH = 16;
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] done = '0;
  logic [15:0] dat [8];
  always #5 clk = ~clk;
  rr_arb8x16_if #(.WIDTH(16)) bus ();
  rr_arb8x16 #(.WIDTH(16), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.req  = req;
  assign bus.done = done;
  assign bus.i0 = dat[0];
  assign bus.i1 = dat[1];
  assign bus.i2 = dat[2];
  assign bus.i3 = dat[3];
  assign bus.i4 = dat[4];
  assign bus.i5 = dat[5];
  assign bus.i6 = dat[6];
  assign bus.i7 = dat[7];
  typedef struct packed {
    logic [7:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic [15:0] out;
    logic        timeout;
  } obs_t;
  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_owner = 7;
  bit m_busy = 1'b0;
  int m_hold = 0;
  logic [15:0] m_out = '0;
  bit m_to = 1'b0;
  // reference model: owner/busy as plain integers, round robin by modular scan
  always @(posedge clk) begin
    obs_t e;
    bit r;
    if (!rst_n) begin
      m_owner = 7; m_busy = 1'b0; m_hold = 0; m_out = '0; m_to = 1'b0;
    end else begin
      m_out = m_busy ? dat[m_owner] : 16'h0;
      m_to = 1'b0;
      if (!m_busy) begin
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_owner + k) % 8;
          if (req[c]) begin
            m_owner = c; m_busy = 1'b1; m_hold = 0;
            break;
          end
        end
      end else begin
        r = !req[m_owner] || done[m_owner];
        if (r) m_busy = 1'b0;
        else if (TO && m_hold == MH - 1) begin m_busy = 1'b0; m_to = 1'b1; end
        else m_hold++;
      end
    end
    e = '{gnt: m_busy ? 8'(1 << m_owner) : 8'h00, owner: 3'(m_owner), busy: m_busy, out: m_out, timeout: m_to};
    exp_q.push_back(e);
  end
  always @(posedge clk) begin
    obs_t a;
    obs_t e;
    #1;
    a = '{gnt: bus.gnt, owner: bus.owner, busy: bus.busy, out: bus.out, timeout: bus.timeout};
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty @%0t: no expectation queued", $time);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard @%0t: got gnt=%h owner=%0d busy=%b out=%h timeout=%b, want gnt=%h owner=%0d busy=%b out=%h timeout=%b",
                 $time, a.gnt, a.owner, a.busy, a.out, a.timeout, e.gnt, e.owner, e.busy, e.out, e.timeout);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
    end
  endtask
  task automatic step(input logic [7:0] r, input logic [7:0] d);
    @(negedge clk);
    req = r;
    done = d;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; done = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int n0, nto, seen1;
    bit run0;
    for (int k = 0; k < 8; k++) dat[k] = 16'(k * 16'h1111 + 16'h0101);
    do_reset();
    dat[0] = 16'hA5A5;
    step(8'h01, 8'h00);
    step(8'h01, 8'h00); chk("t1_gnt", 32'(bus.gnt), 32'h01); chk("t1_busy", 32'(bus.busy), 32'h1);
    step(8'h00, 8'h00); chk("t1_out", 32'(bus.out), 32'hA5A5);
    step(8'h00, 8'h00); chk("t1_gnt_clear", 32'(bus.gnt), 32'h00);
    step(8'h00, 8'h00); chk("t1_out_clear", 32'(bus.out), 32'h0000);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 8'h00);
      if (k > 0) chk("t2_dead_cycle", 32'(bus.gnt), 32'h00);
      step(8'hFF, 8'h00); chk("t2_order", 32'(bus.gnt), 32'(8'd1 << (k % 8)));
      step(8'hFF, 8'(8'd1 << (k % 8)));
    end
    do_reset();
    dat[1] = 16'hFFFF; dat[3] = 16'h0F0F;
    step(8'h08, 8'h00);
    step(8'h08, 8'h00); chk("t3_owner3", 32'(bus.gnt), 32'h08);
    step(8'h0A, 8'h00);
    step(8'h0A, 8'h00); chk("t3_out_masked", 32'(bus.out), 32'h0F0F);
    step(8'h02, 8'h00);
    step(8'h02, 8'h00); chk("t3_dead", 32'(bus.gnt), 32'h00);
    step(8'h02, 8'h00); chk("t3_wrap_to_1", 32'(bus.gnt), 32'h02);
    do_reset();
    step(8'h04, 8'h00);
    step(8'h04, 8'h00); chk("t4_owner2", 32'(bus.gnt), 32'h04);
    step(8'h04, 8'h20);
    step(8'h04, 8'h00); chk("t4_ignore_done5", 32'(bus.gnt), 32'h04);
    step(8'h04, 8'h00); chk("t4_still_owner2", 32'(bus.gnt), 32'h04);
    do_reset();
    n0 = 0; nto = 0; seen1 = 0; run0 = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step(8'h03, 8'h00);
      if (bus.gnt == 8'h01 && run0) n0++;
      else if (n0 > 0) run0 = 1'b0;
      if (bus.timeout) nto++;
      if (bus.gnt == 8'h02) seen1 = 1;
    end
`ifdef ARB_TIMEOUT_EN
    chk("t5_hold_len", 32'(n0), 32'(MH));
    chk("t5_timeout_seen", 32'(nto > 0), 32'h1);
    chk("t5_owner1_granted", 32'(seen1), 32'h1);
`else
    chk("t5_hold_forever", 32'(n0 >= 100), 32'h1);
    chk("t5_no_timeout", 32'(nto), 32'h0);
    chk("t5_owner1_never", 32'(seen1), 32'h0);
`endif
    do_reset();
    dat[6] = 16'h6C6C;
    step(8'h40, 8'h00);
    step(8'h40, 8'h00); chk("t6_owner6", 32'(bus.gnt), 32'h40);
    step(8'h40, 8'h00); chk("t6_out", 32'(bus.out), 32'h6C6C);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(bus.gnt), 32'h00);
    chk("t6_async_out", 32'(bus.out), 32'h0000);
    chk("t6_async_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req = 8'hC0;
    step(8'hC0, 8'h00); chk("t6_first_grant6", 32'(bus.gnt), 32'h40);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] flip, dn;
      for (int k = 0; k < 8; k++) dat[k] = 16'($urandom);
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      dn = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(req ^ flip, dn);
    end
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
